// File: rtl/arb_req_client.sv
// N-channel burst requester for a combinational priority arbiter, with a sticky
// checker that flags grant vectors the arbiter protocol never allows.
module arb_req_lane #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [LW-1:0] i_len,
  input  logic          i_gnt,
  output logic          o_req,
  output logic          o_done
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [0:0]    r_state;
  logic [LW-1:0] r_cnt;
  logic          r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          // a zero length still costs one beat
          r_cnt   <= (i_len == '0) ? LW'(1) : i_len;
          r_state <= S_REQ;
        end
        S_REQ: if (i_gnt) begin
          if (r_cnt == LW'(1)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - LW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req  = (r_state == S_REQ);
  assign o_done = r_done;
endmodule

module arb_req_client #(
  parameter int N  = 4,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:N-1]  start,
  input  logic [N*LW-1:0] len,
  output logic [0:N-1]  arb_req,
  input  logic [0:N-1]  arb_gnt,
  output logic [0:N-1]  beat,
  output logic [0:N-1]  busy,
  output logic [0:N-1]  done,
  output logic          err
);
  logic w_viol;
  logic w_hi;
  logic r_err;

  for (genvar g = 0; g < N; g++) begin : g_lane
    arb_req_lane #(.LW(LW)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_start(start[g]),
      .i_len  (len[g*LW +: LW]),
      .i_gnt  (arb_gnt[g]),
      .o_req  (arb_req[g]),
      .o_done (done[g])
    );
  end

  // w_hi tracks whether any lower index already requests when bit i is examined
  always_comb begin
    w_viol = 1'b0;
    w_hi   = 1'b0;
    if ((arb_gnt & (arb_gnt - 1'b1)) != '0) w_viol = 1'b1;
    if (arb_gnt == '0 && arb_req != '0) w_viol = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (arb_gnt[i] && (!arb_req[i] || w_hi)) w_viol = 1'b1;
      if (arb_req[i]) w_hi = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= r_err | w_viol;
  end

  assign busy = arb_req;
  assign beat = arb_req & arb_gnt;
  assign err  = r_err;
endmodule

// File: tb/tb_arb_req_client.sv
// Bench for arb_req_client: fixed-priority arbiter model, burst-level reference
// model, directed scenarios plus randomized traffic and grant fault injection.
module tb_arb_req_client;
  localparam int N  = 4;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [0:N-1] start, arb_req, arb_gnt, beat, busy, done;
  logic [N*LW-1:0] len;
  logic err;

  logic force_en;
  logic [0:N-1] gnt_force, gnt_extra, w_arb;

  int total = 0;
  int bad = 0;

  // reference model state
  int rem[N];
  logic [0:N-1] mreq, mdone;
  logic merr;
  int ddone[N];

  always #5 clk = ~clk;

  arb_req_client #(.N(N), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .arb_req(arb_req), .arb_gnt(arb_gnt), .beat(beat),
    .busy(busy), .done(done), .err(err)
  );

  // arbiter: lowest-index request wins
  always_comb begin
    w_arb = '0;
    for (int i = N-1; i >= 0; i--)
      if (arb_req[i]) begin
        w_arb = '0;
        w_arb[i] = 1'b1;
      end
  end
  assign arb_gnt = force_en ? gnt_force : (w_arb | gnt_extra);

  function automatic logic [4*N:0] expv();
    return {mreq, mreq, mdone, mreq & arb_gnt, merr};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin rem[i] = 0; ddone[i] = 0; end
    mreq = '0; mdone = '0; merr = 1'b0;
  endtask

  task automatic set_len(input int ch, input int v);
    len[ch*LW +: LW] = LW'(v);
  endtask

  // advance one clock: model the edge from current inputs, land on next negedge
  task automatic tick();
    logic [0:N-1] nreq, ndn;
    int nrem[N];
    logic ne;
    int ones, first;
    #1;
    nreq = mreq; ndn = '0; nrem = rem; ne = merr;
    for (int i = 0; i < N; i++) begin
      if (mreq[i]) begin
        if (arb_gnt[i]) begin
          if (rem[i] == 1) begin nreq[i] = 1'b0; ndn[i] = 1'b1; nrem[i] = 0; end
          else nrem[i] = rem[i] - 1;
        end
      end else if (start[i]) begin
        nrem[i] = (len[i*LW +: LW] == '0) ? 1 : int'(len[i*LW +: LW]);
        nreq[i] = 1'b1;
      end
    end
    ones = 0; first = N;
    for (int i = 0; i < N; i++) if (arb_gnt[i]) ones++;
    for (int i = N-1; i >= 0; i--) if (mreq[i]) first = i;
    if (ones > 1) ne = 1'b1;
    if (ones == 0 && mreq != '0) ne = 1'b1;
    for (int i = 0; i < N; i++)
      if (arb_gnt[i] && (!mreq[i] || i != first)) ne = 1'b1;
    @(posedge clk);
    mreq = nreq; mdone = ndn; rem = nrem; merr = ne;
    @(negedge clk);
    for (int i = 0; i < N; i++) if (done[i]) ddone[i]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = '0; force_en = 1'b0; gnt_extra = '0; gnt_force = '0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({arb_req, busy, done, beat, err} !== '0)
      begin bad++; $display("FAIL reset_hold: got %b want 0", {arb_req, busy, done, beat, err}); end
    rst_n = 1'b1;
    model_clear();
    repeat (3) begin
      tick();
      total++;
      if ({arb_req, busy, done, beat, err} !== expv())
        begin bad++; $display("FAIL reset_idle: got %b want %b", {arb_req, busy, done, beat, err}, expv()); end
    end
  endtask

  task automatic test_single();
    do_reset();
    start[2] = 1'b1; set_len(2, 3);
    tick();
    start = '0;
    for (int c = 1; c <= 6; c++) begin
      total++;
      if ({arb_req, busy, done, beat, err} !== expv())
        begin bad++; $display("FAIL single_model c=%0d: got %b want %b", c, {arb_req, busy, done, beat, err}, expv()); end
      total++;
      if (arb_req !== ((c <= 3) ? 4'b0010 : 4'b0000) || done !== ((c == 4) ? 4'b0010 : 4'b0000))
        begin bad++; $display("FAIL single_timing c=%0d: req=%b done=%b", c, arb_req, done); end
      tick();
    end
  endtask

  task automatic test_pair();
    int d0, d3;
    do_reset();
    d0 = -1; d3 = -1;
    start[0] = 1'b1; start[3] = 1'b1; set_len(0, 2); set_len(3, 2);
    tick();
    start = '0;
    for (int c = 1; c <= 7; c++) begin
      if (done[0]) d0 = c;
      if (done[3]) d3 = c;
      total++;
      if ({arb_req, busy, done, beat, err} !== expv())
        begin bad++; $display("FAIL pair_model c=%0d: got %b want %b", c, {arb_req, busy, done, beat, err}, expv()); end
      tick();
    end
    total++;
    if (d0 != 3 || d3 != 5)
      begin bad++; $display("FAIL pair_order: done0 at %0d done3 at %0d want 3 and 5", d0, d3); end
  endtask

  task automatic test_preempt();
    int reqcyc, d1, d3;
    do_reset();
    reqcyc = 0; d1 = -1; d3 = -1;
    start[3] = 1'b1; set_len(3, 4);
    for (int c = 0; c <= 10; c++) begin
      if (c == 1) start[3] = 1'b0;
      if (c == 2) begin start[1] = 1'b1; set_len(1, 1); end
      if (c == 3) start[1] = 1'b0;
      if (arb_req[3]) reqcyc++;
      if (done[1] && d1 < 0) d1 = c;
      if (done[3] && d3 < 0) d3 = c;
      total++;
      if ({arb_req, busy, done, beat, err} !== expv())
        begin bad++; $display("FAIL preempt_model c=%0d: got %b want %b", c, {arb_req, busy, done, beat, err}, expv()); end
      tick();
    end
    total++;
    if (reqcyc != 5 || d1 < 0 || d3 <= d1 || ddone[3] != 1)
      begin bad++; $display("FAIL preempt: req3 cycles=%0d want 5, done1@%0d done3@%0d", reqcyc, d1, d3); end
  endtask

  task automatic test_len0();
    do_reset();
    start[1] = 1'b1; set_len(1, 0);
    tick();
    set_len(1, 5);
    tick();
    start = '0;
    repeat (6) begin
      total++;
      if ({arb_req, busy, done, beat, err} !== expv())
        begin bad++; $display("FAIL len0_model: got %b want %b", {arb_req, busy, done, beat, err}, expv()); end
      tick();
    end
    total++;
    if (ddone[1] != 1)
      begin bad++; $display("FAIL len0_count: got %0d dones want 1", ddone[1]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        start[i] = ($urandom_range(0, 3) == 0);
        set_len(i, int'($urandom_range(0, 15)));
      end
      total++;
      if ({arb_req, busy, done, beat, err} !== expv())
        begin bad++; $display("FAIL random c=%0d: got %b want %b", c, {arb_req, busy, done, beat, err}, expv()); end
      tick();
    end
    start = '0;
  endtask

  task automatic test_fault();
    do_reset();
    force_en = 1'b1; gnt_force = 4'b1100;
    tick();
    force_en = 1'b0;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL fault_multi: err=%b want 1", err); end
    repeat (3) tick();
    total++;
    if (err !== 1'b1 || {arb_req, busy, done, beat, err} !== expv())
      begin bad++; $display("FAIL fault_sticky: got %b want %b", {arb_req, busy, done, beat, err}, expv()); end

    do_reset();
    gnt_extra = 4'b0001;
    tick();
    gnt_extra = '0;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL fault_idle: err=%b want 1", err); end

    do_reset();
    start[0] = 1'b1; set_len(0, 8);
    tick();
    start = '0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({arb_req, busy, done, beat, err} !== '0)
      begin bad++; $display("FAIL fault_rst: got %b want 0", {arb_req, busy, done, beat, err}); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      total++;
      if ({arb_req, busy, done, beat, err} !== expv() || ddone[0] != 0)
        begin bad++; $display("FAIL fault_after_rst: got %b want %b dones=%0d", {arb_req, busy, done, beat, err}, expv(), ddone[0]); end
    end
  endtask

  initial begin
    start = '0; len = '0; force_en = 1'b0; gnt_force = '0; gnt_extra = '0;
    model_clear();
    test_reset();
    test_single();
    test_pair();
    test_preempt();
    test_len0();
    test_random();
    test_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
